// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver state encoding
package uart_pkg;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} uart_rx_state_t;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_START_MID = 7;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line plus the receiver's byte/flag handshake with the APB side
interface uart_rx_if;
  logic rx;
  logic rdy_clr;
  logic [7:0] data_out;
  logic rdy;
  logic frame_err;
  logic overrun;
  modport master (output rx, rdy_clr, input data_out, rdy, frame_err, overrun);
  modport slave (input rx, rdy_clr, output data_out, rdy, frame_err, overrun);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider emitting a one-cycle oversample tick every TICK_DIV clocks
module uart_baud_tick #(
  parameter int TICK_DIV = 27
) (
  input  logic PCLK,
  input  logic PRESETn,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt;
  logic wrap;
  assign wrap = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge PCLK or posedge PRESETn)
    if (PRESETn) begin
      cnt <= '0;
      tick <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      tick <= wrap;
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled 8N1 receiver with sticky rdy, overrun and frame_err flags
module uart_rx
  import uart_pkg::*;
#(
  parameter int TICK_DIV = 27
) (
  input logic PCLK,
  input logic PRESETn,
  uart_rx_if.slave bus
);
  localparam int OVERSAMPLE = UART_OVERSAMPLE;
  localparam logic [2:0] IDLE = RX_IDLE;
  localparam logic [2:0] START = RX_START;
  localparam logic [2:0] DATA = RX_DATA;
  localparam logic [2:0] STOP = RX_STOP;
  localparam logic [2:0] WAIT_IDLE = RX_WAIT_IDLE;
  logic rx_m, rx_s, tick, mid, last, done, ferr;
  logic [2:0] state, bi;
  logic [3:0] sc;
  logic [7:0] shreg;
  uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (.PCLK(PCLK), .PRESETn(PRESETn), .tick(tick));
  assign mid = tick && sc == 4'(UART_START_MID);
  assign last = tick && sc == 4'(OVERSAMPLE - 1);
  assign done = state == STOP && last && rx_s;
  assign ferr = state == STOP && last && !rx_s;
  always_ff @(posedge PCLK or posedge PRESETn)
    if (PRESETn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      state <= IDLE;
      sc <= '0;
      bi <= '0;
      shreg <= '0;
      bus.data_out <= '0;
      bus.rdy <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
      sc <= (state == IDLE || (state == START && mid)) ? '0 : tick ? sc + 1'b1 : sc;
      bi <= state == START ? '0 : (state == DATA && last) ? bi + 1'b1 : bi;
      if (state == DATA && last) shreg[bi] <= rx_s;
      case (state)
        IDLE:      if (!rx_s) state <= START;
        START:     if (mid) state <= rx_s ? IDLE : DATA;
        DATA:      if (last && bi == 3'(UART_DATA_BITS - 1)) state <= STOP;
        STOP:      if (last) state <= rx_s ? IDLE : WAIT_IDLE;
        WAIT_IDLE: if (rx_s) state <= IDLE;
        default:   state <= IDLE;
      endcase
      // a completing byte or frame error outranks a simultaneous clear
      if (done) bus.data_out <= shreg;
      bus.rdy <= done || (bus.rdy && !bus.rdy_clr);
      bus.overrun <= !bus.rdy_clr && (bus.overrun || (done && bus.rdy));
      bus.frame_err <= ferr || (bus.frame_err && !bus.rdy_clr);
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver feeding the UART APB interface. It deserialises 8N1 frames arriving on the `rx` line, then presents the byte on `data_out` with a sticky `rdy` flag. `rdy` is held until the APB side pulses `rdy_clr`. It sits directly upstream of the APB interface's read path, in the `PCLK` domain.

## Interface
- `TICK_DIV`, 27: `PCLK` cycles per oversample tick (50 MHz / (115200 × 16), truncated); legal range ≥ 1.
- `OVERSAMPLE`, 16: ticks per bit; fixed at 16, not overridable.

- `PCLK` in 1: single clock; every register is clocked on the rising edge.
- `PRESETn` in 1: reset, asynchronous and active-high despite the name; `PRESETn` = 1 resets.
- `rx` in 1: serial line; idle high; asynchronous to `PCLK`.
- `rdy_clr` in 1: one-cycle pulse; clears `rdy`, `overrun` and `frame_err`.
- `data_out` out 8: last good byte, LSB received first.
- `rdy` out 1: a valid byte is waiting in `data_out`.
- `frame_err` out 1: sticky; a stop bit was sampled low.
- `overrun` out 1: sticky; a byte completed while `rdy` was already 1.

## Operation
- `rx` passes through a 2-flop synchroniser; its reset value is 1. All decisions use the synchronised `rx_s`.
- Tick generator: counter 0..`TICK_DIV`-1; tick pulses one cycle at wrap; runs freely.
- FSM states: `IDLE`, `START`, `DATA`, `STOP`, `WAIT_IDLE`. It holds a tick counter `sc` (0..15) and a bit index `bi` (0..7).
- `IDLE`: on `rx_s` = 0, go to `START` with `sc` = 0. The falling-edge check is made every `PCLK`, not only on ticks.
- `START`: at tick with `sc` = 7 (mid start bit):
  - `rx_s` = 0: go to `DATA`, `sc` = 0, `bi` = 0.
  - `rx_s` = 1: false start; go to `IDLE`, no flags change.
- `DATA`: at tick with `sc` = 15, shift `rx_s` into `shreg[bi]`. If `bi` = 7, go to `STOP`; else `bi`++.
- `STOP`: at tick with `sc` = 15:
  - `rx_s` = 1: `data_out` ← `shreg`, `rdy` ← 1. `overrun` ← 1 if `rdy` was already 1. Go to `IDLE`.
  - `rx_s` = 0: `frame_err` ← 1; byte discarded; `data_out` and `rdy` unchanged. Go to `WAIT_IDLE`.
- `WAIT_IDLE`: stay until `rx_s` = 1 (break or stuck-low line), then `IDLE`.
- `sc` increments on each tick and wraps 15 → 0.

## Timing
- Reset values:
  - `data_out` = 0x00; `rdy`, `frame_err`, `overrun` = 0.
  - FSM `IDLE`; synchroniser flops = 1; counters = 0.
- Reset mid-frame aborts immediately. The next frame is recognised only after a fresh falling edge.
- Latency: `rdy` rises on the `PCLK` edge after the mid-stop-bit tick. That is ≈ 9.5 bit periods + 2 `PCLK` after the start edge on `rx`.
- Samples are taken at bit centres, ±1 tick jitter from start-edge alignment.
- `rdy_clr` clears the flags on the next edge:
  - together with byte completion in the same cycle: completion wins; `rdy` = 1, `overrun` not set, `data_out` = new byte.
  - together with a frame error in the same cycle: `frame_err` = 1.
- Back-to-back frames: `STOP` exits at mid stop bit, so the next start edge is caught with half a bit of margin.

## Structure
- Package `uart_pkg`:
  - state enum `uart_rx_state_t`;
  - `UART_OVERSAMPLE` = 16;
  - `UART_DATA_BITS` = 8;
  - `UART_START_MID` = 7.
- Sub-module `uart_baud_tick` (parameter `TICK_DIV`; ports `PCLK`, `PRESETn`, `tick`). It is shared later with the transmitter.

## Test plan
All scenarios use `TICK_DIV` = 1, so one bit = 16 `PCLK`.
- Frame 0xA5 (LSB first, stop high) → `rdy` = 1, `data_out` = 0xA5 within 154 `PCLK` of the start edge; `frame_err` = 0.
- 3-cycle low glitch on idle `rx` → FSM back in `IDLE`; `rdy` stays 0; no flags.
- Frame 0x3C with stop bit low, then `rx` held low 40 bits → `frame_err` = 1, `rdy` = 0. No frame accepted until `rx` goes high. A following 0x55 then gives `data_out` = 0x55.
- Two frames 0x11, 0x22 with no `rdy_clr` → `data_out` = 0x22, `overrun` = 1. A `rdy_clr` pulse then gives `rdy` = `overrun` = 0.
- `rdy_clr` in the same cycle as 0x7E completes, with `rdy` previously 0 → `rdy` = 1, `data_out` = 0x7E, `overrun` = 0.
- `PRESETn` asserted at bit 4 of 0xF0, released, then 0x0F sent → only 0x0F reported; all outputs were 0 during reset.
